// File: rtl/spi_mem_arbiter_if.sv
// Core-side request/response bus of the SPI memory arbiter.
// The rv32e core (master) drives the fetch and data requests. The arbiter
// (slave) returns read data and one-cycle completion pulses.
interface spi_mem_arbiter_if;
    logic        if_req;
    logic [23:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        d_req;
    logic        d_we;
    logic [23:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  if_rdata, if_done, d_rdata, d_done
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output if_rdata, if_done, d_rdata, d_done
    );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Shares a single SPI memory bus between the instruction-fetch port and the
// data load/store port of the core. Requests are arbitrated round-robin.
// Each granted request becomes one 64-bit mode-0 SPI frame:
// command byte, 24-bit address, then one 32-bit data word.
// Read data arrives little-endian by byte: the first received data byte lands
// in rdata[7:0].
module spi_mem_arbiter #(
    parameter int CLK_DIV = 1,
    parameter int CS_GAP  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_mem_arbiter_if.slave        bus,
    output logic                    spi_sclk,
    output logic                    spi_cs_n,
    output logic                    spi_mosi,
    input  logic                    spi_miso
);

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // The FINISH cycle already counts as the first cs_n-high cycle, so GAP
    // only has to cover the remaining CS_GAP-1 cycles.
    localparam int GAP_LAST_I = (CS_GAP > 1) ? CS_GAP - 2 : 0;
    localparam int GAP_W      = (GAP_LAST_I > 0) ? $clog2(GAP_LAST_I + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH,
        GAP
    } state_t;

    state_t             state_q;
    logic [63:0]        txFrame_q;
    logic [31:0]        rxWord_q;
    logic [DIV_W-1:0]   divCnt_q;
    logic [5:0]         bitCnt_q;
    logic [GAP_W-1:0]   gapCnt_q;
    logic               grantData_q;
    logic               grantWe_q;
    logic               lastData_q;
    logic               sclk_q;
    logic               csN_q;
    logic               ifDone_q;
    logic               dDone_q;
    logic [31:0]        ifRdata_q;
    logic [31:0]        dRdata_q;

    logic               grantValid_d;
    logic               grantData_d;
    logic [63:0]        frame_d;
    logic [31:0]        rxSwapped;

    // Round-robin pick and the frame that the winner would send.
    // On a tie, the requester that did not win last time gets the grant.
    // The frame is only latched when a grant actually happens in IDLE.
    always_comb begin
        grantValid_d = bus.if_req | bus.d_req;
        grantData_d  = bus.d_req & (~bus.if_req | ~lastData_q);
        frame_d      = {CMD_READ, bus.if_addr, 32'h0000_0000};
        if (grantData_d) begin
            frame_d = {(bus.d_we ? CMD_WRITE : CMD_READ), bus.d_addr,
                       (bus.d_we ? bus.d_wdata : 32'h0000_0000)};
        end
        rxSwapped = {rxWord_q[7:0], rxWord_q[15:8], rxWord_q[23:16], rxWord_q[31:24]};
    end

    // Transaction sequencer. Every SPI pin, done pulse and read-data word is
    // registered here, so the outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            txFrame_q   <= '0;
            rxWord_q    <= '0;
            divCnt_q    <= '0;
            bitCnt_q    <= '0;
            gapCnt_q    <= '0;
            grantData_q <= 1'b0;
            grantWe_q   <= 1'b0;
            lastData_q  <= 1'b0;
            sclk_q      <= 1'b0;
            csN_q       <= 1'b1;
            ifDone_q    <= 1'b0;
            dDone_q     <= 1'b0;
            ifRdata_q   <= '0;
            dRdata_q    <= '0;
        end else begin
            ifDone_q <= 1'b0;
            dDone_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grantValid_d) begin
                        grantData_q <= grantData_d;
                        grantWe_q   <= grantData_d & bus.d_we;
                        lastData_q  <= grantData_d;
                        txFrame_q   <= frame_d;
                        divCnt_q    <= '0;
                        bitCnt_q    <= '0;
                        sclk_q      <= 1'b0;
                        csN_q       <= 1'b0;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (divCnt_q == DIV_LAST) begin
                        divCnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q   <= 1'b1;
                            rxWord_q <= {rxWord_q[30:0], spi_miso};
                        end else if (bitCnt_q == 6'd63) begin
                            sclk_q    <= 1'b0;
                            csN_q     <= 1'b1;
                            txFrame_q <= '0;
                            state_q   <= FINISH;
                            if (grantData_q) begin
                                dDone_q <= 1'b1;
                                if (!grantWe_q) begin
                                    dRdata_q <= rxSwapped;
                                end
                            end else begin
                                ifDone_q  <= 1'b1;
                                ifRdata_q <= rxSwapped;
                            end
                        end else begin
                            sclk_q    <= 1'b0;
                            txFrame_q <= {txFrame_q[62:0], 1'b0};
                            bitCnt_q  <= bitCnt_q + 6'd1;
                        end
                    end else begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end
                FINISH: begin
                    gapCnt_q <= '0;
                    state_q  <= (CS_GAP > 1) ? GAP : IDLE;
                end
                GAP: begin
                    if (gapCnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_sclk     = sclk_q;
    assign spi_cs_n     = csN_q;
    assign spi_mosi     = txFrame_q[63];
    assign bus.if_done  = ifDone_q;
    assign bus.d_done   = dDone_q;
    assign bus.if_rdata = ifRdata_q;
    assign bus.d_rdata  = dRdata_q;

endmodule
